// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and sizes for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// rr_pick: combinational search for the first set request at or after ptr, wrapping.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    always_comb begin
        found = 1'b0;
        idx   = ptr;
        // The SEL_W-bit sum wraps 3->0 on its own.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[ptr + SEL_W'(i)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 mux arbiter with registered grant and combinational data mux.
// Optional RR_MUX_ARBITER_LOCK_EN adds a lock input that re-grants the same lane.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    input  logic                     out_ready,
`ifdef RR_MUX_ARBITER_LOCK_EN
    input  logic                     lock,
`endif
    output logic [SEL_W-1:0]         sel,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [NUM_REQ-1:0]       ack
);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 out_valid_q, out_valid_d;

    logic                 hs;
    logic                 lock_w;
    logic [SEL_W-1:0]     adv_ptr;
    logic [NUM_REQ-1:0]   pick_req;
    logic [SEL_W-1:0]     pick_ptr;
    logic                 pick_found;
    logic [SEL_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0][WIDTH-1:0] lanes;

`ifdef RR_MUX_ARBITER_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    assign hs = out_valid_q & out_ready;

    // One search serves both cases: from ptr when idle, from the post-handshake ptr when busy.
    always_comb begin
        adv_ptr  = lock_w ? sel_q : sel_q + SEL_W'(1);
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == BUSY) begin
            pick_ptr = adv_ptr;
            pick_req = lock_w ? req : (req & ~gnt_q);
        end
    end

    rr_pick u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = BUSY;
                    sel_d       = pick_idx;
                    gnt_d       = onehot(pick_idx);
                    out_valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (hs) begin
                    ptr_d = adv_ptr;
                    if (pick_found) begin
                        sel_d = pick_idx;
                        gnt_d = onehot(pick_idx);
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = '0;
                        out_valid_d = 1'b0;
                    end
                end else if (!req[sel_q]) begin
                    // Requester withdrew: drop the grant without touching ptr.
                    state_d     = IDLE;
                    gnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign lanes     = in_data;
    assign out_data  = lanes[sel_q];
    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign ack       = gnt_q & {NUM_REQ{hs}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus protocol-obeying random requesters,
// all checked against a cycle-level round-robin model and a fairness monitor.
module tb_rr_mux_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = '0;
    logic [4*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;
    logic           lock_i = 1'b0;
    logic [1:0]     sel;
    logic [3:0]     gnt;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic [3:0]     ack;

    int  n_chk = 0;
    int  n_fail = 0;
    bit  run_cmp = 1'b0;
    logic [3:0] a_prev;
    int  wait_cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
`ifdef RR_MUX_ARBITER_LOCK_EN
        .lock      (lock_i),
`endif
        .sel       (sel),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ack       (ack)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // First requesting lane scanning upward from p with wrap, or -1.
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Model state: whether a transfer is offered, which lane, and the round-robin start.
    bit m_busy = 1'b0;
    int m_sel = 0;
    int m_ptr = 0;
    int m_adv, m_idle_pick, m_busy_pick;

    always_comb begin
        m_adv       = lock_i ? m_sel : (m_sel + 1) % 4;
        m_idle_pick = pick(req, m_ptr);
        m_busy_pick = pick(lock_i ? req : (req & ~(4'b0001 << m_sel)), m_adv);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_ptr  <= 0;
            m_sel  <= 0;
        end else if (!m_busy) begin
            if (m_idle_pick >= 0) begin
                m_busy <= 1'b1;
                m_sel  <= m_idle_pick;
            end
        end else if (out_ready) begin
            m_ptr <= m_adv;
            if (m_busy_pick >= 0) m_sel <= m_busy_pick;
            else                  m_busy <= 1'b0;
        end else if (!req[m_sel]) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_busy));
            chk("gnt", 32'(gnt), m_busy ? 32'(4'b0001 << m_sel) : 32'd0);
            chk("ack", 32'(ack), (m_busy && out_ready) ? 32'(4'b0001 << m_sel) : 32'd0);
            if (m_busy) begin
                chk("sel", 32'(sel), 32'(m_sel));
                chk("out_data", 32'(out_data), 32'(in_data[m_sel*W +: W]));
            end
`ifndef RR_MUX_ARBITER_LOCK_EN
            for (int i = 0; i < 4; i++) begin
                if (!req[i] || ack[i]) wait_cnt[i] = 0;
                else if (ack != 4'b0000) begin
                    wait_cnt[i] = wait_cnt[i] + 1;
                    chk("fairness_wait", 32'(wait_cnt[i] <= 3), 32'd1);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; out_ready = 1'b0; lock_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_ack [5];
        exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Pin the model's search.
        chk("model_pick_a", 32'(pick(4'b0101, 1)), 32'd2);
        chk("model_pick_b", 32'(pick(4'b1000, 0)), 32'd3);
        chk("model_pick_c", 32'(pick(4'b0000, 2)), 32'hFFFF_FFFF);

        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        do_reset();
        run_cmp = 1'b1;

        // Single transfer on lane 0.
        req = 4'b0001; in_data[7:0] = 8'hA5; out_ready = 1'b1;
        @(negedge clk); chk("single_lat", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sel", 32'(sel), 32'd0);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_ack", 32'(ack), 32'b0001);
        tick(); req = 4'b0000;
        @(negedge clk); chk("single_idle", 32'(out_valid), 32'd0);

        // All four requesting: rotate one per cycle.
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk); chk("rotate_ack", 32'(ack), 32'(exp_ack[k]));
        end

        // Stall holds the grant, then lane 2 follows.
        do_reset();
        req = 4'b0101; out_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_sel", 32'(sel), 32'd0);
            chk("stall_gnt", 32'(gnt), 32'b0001);
            chk("stall_ack", 32'(ack), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("stall_release_ack", 32'(ack), 32'b0001);
        tick(); req = 4'b0100;
        @(negedge clk);
        chk("next_sel", 32'(sel), 32'd2);
        chk("next_gnt", 32'(gnt), 32'b0100);

        // Withdrawal leaves ptr at 0.
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        tick();
        @(negedge clk); chk("wd_gnt", 32'(gnt), 32'b0010);
        tick(); req = 4'b0000;
        @(negedge clk); chk("wd_ack", 32'(ack), 32'd0);
        tick();
        @(negedge clk); chk("wd_valid", 32'(out_valid), 32'd0);
        tick(); req = 4'b0011;
        tick();
        @(negedge clk);
        chk("wd_regrant_sel", 32'(sel), 32'd0);
        chk("wd_regrant_gnt", 32'(gnt), 32'b0001);

        // Asynchronous reset while busy.
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        tick(); rst = 1'b0; req = 4'b1000;
        tick();
        @(negedge clk);
        chk("arst_after_gnt", 32'(gnt), 32'b1000);
        chk("arst_after_sel", 32'(sel), 32'd3);

`ifdef RR_MUX_ARBITER_LOCK_EN
        do_reset();
        lock_i = 1'b1; req = 4'b0011; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk); chk("lock_ack", 32'(ack), 32'b0001);
        end
        #1 lock_i = 1'b0;
        tick();
        @(negedge clk); chk("unlock_ack", 32'(ack), 32'b0010);
`endif

        // Random requesters that hold req until ack, occasionally withdrawing.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); a_prev = ack;
            tick();
            for (int i = 0; i < 4; i++) begin
                if (a_prev[i]) begin
                    req[i] = 1'($urandom_range(0, 1));
                    in_data[i*W +: W] = 8'($urandom);
                end else if (req[i]) begin
                    if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    in_data[i*W +: W] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
`ifdef RR_MUX_ARBITER_LOCK_EN
            lock_i = ($urandom_range(0, 7) == 0);
`endif
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data width per requester lane.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  4  per-requester request, held until its ack.
REQ-005 SHALL have port in_data  input  4*WIDTH  lane i at bits [i*WIDTH +: WIDTH], held stable while req[i].
REQ-006 SHALL have port out_ready  input  1  downstream accept.
REQ-007 SHALL have port sel  output  2  registered mux select, index of granted lane.
REQ-008 SHALL have port gnt  output  4  registered one-hot grant, equal to 1<<sel when out_valid, else 0.
REQ-009 SHALL have port out_data  output  WIDTH  in_data lane selected by sel (combinational mux).
REQ-010 SHALL have port out_valid  output  1  registered; high in BUSY.
REQ-011 SHALL have port ack  output  4  one-hot pulse, gnt & {4{out_valid & out_ready}}.

Function
REQ-012 SHALL implement states IDLE and BUSY.
REQ-013 IDLE: if req!=0, SHALL grant the first set req at or after ptr (wrap 3->0), load sel/gnt, set out_valid, enter BUSY next cycle; latency req->out_valid = 1 cycle.
REQ-014 BUSY: SHALL hold sel, gnt, out_valid constant until handshake (out_valid & out_ready).
REQ-015 On handshake SHALL set ptr = sel+1 mod 4 and, in the same cycle, arbitrate remaining req (excluding acked lane) from the new ptr; if any, stay BUSY with new grant (one transfer per cycle), else go IDLE with out_valid=0.
REQ-016 BUSY with req[sel] low and no handshake (requester withdrew): SHALL go IDLE, out_valid=0, no ack, ptr unchanged.
REQ-017 A requester SHALL never wait more than 3 handshakes while its req is held (round-robin fairness).
REQ-018 New req arriving while BUSY SHALL not pre-empt the current grant.
REQ-019 out_data SHALL equal in_data[sel] at all times; value is don't-care when out_valid=0.

Reset
REQ-020 On rst high, asynchronously: state=IDLE, ptr=0, sel=0, gnt=0, out_valid=0; ack=0.
REQ-021 Reset mid-transfer SHALL drop out_valid immediately and issue no ack; first grant after release starts search at lane 0.

Configuration
REQ-022 Macro RR_MUX_ARBITER_LOCK_EN: when defined, SHALL add input lock (1 bit); on handshake with lock=1 ptr SHALL not advance and the same lane SHALL be re-granted if its req is still high.
REQ-023 Without the macro SHALL have no lock port and behave as pure round-robin per REQ-015.

Structure
REQ-024 Shared package rr_mux_arbiter_pkg SHALL hold state enum (IDLE, BUSY), NUM_REQ=4, SEL_W=2.
REQ-025 Priority search from ptr SHALL be a sub-module rr_pick (inputs req, ptr; outputs found, idx), combinational.
REQ-026 Data path SHALL be a plain 4:1 WIDTH-bit mux driven by sel; no data registering.

Verification
REQ-027 Reset then req=4'b0001, in_data lane0=8'hA5, out_ready=1 -> cycle+1 out_valid=1, sel=0, out_data=8'hA5, ack=4'b0001; then IDLE.
REQ-028 req=4'b1111 held, out_ready=1 -> ack sequence 0001,0010,0100,1000,0001, one per cycle.
REQ-029 req=4'b0101, out_ready=0 for 5 cycles -> sel=0, gnt=0001 constant, ack=0; out_ready=1 -> ack=0001 then grant lane 2.
REQ-030 Granted lane 1, out_ready=0, req[1] dropped -> next cycle out_valid=0, ack=0, ptr still 0 (next grant with req=0011 is lane 0).
REQ-031 rst asserted while BUSY -> out_valid=0 and gnt=0 same cycle; after release req=4'b1000 -> grant lane 3.
REQ-032 With RR_MUX_ARBITER_LOCK_EN, lock=1, req=4'b0011, out_ready=1 -> ack=0001 every cycle; lock=0 -> next ack=0010.
